// File: rtl/led_sequencer_if.sv
// Control/output bundle between the LED sequencer and its controller (buttons, UART decoder).
// The master drives start/stop/mode/pattern; the slave (sequencer) drives the LED bank and status.
interface led_sequencer_if #(
  parameter int BITS = 8
);
  logic            START;
  logic            STOP;
  logic [1:0]      MODE;
  logic [BITS-1:0] PATTERN;
  logic [BITS-1:0] OUT;
  logic            BUSY;
  logic            STEP;

  modport master (
    output START, STOP, MODE, PATTERN,
    input  OUT, BUSY, STEP
  );

  modport slave (
    input  START, STOP, MODE, PATTERN,
    output OUT, BUSY, STEP
  );
endinterface

// File: rtl/led_sequencer.sv
// Start/stop controlled LED pattern sequencer: prescaled step tick, IDLE/LOAD/RUN FSM, four animations.
// Optional PWM dimming of the bank is enabled by defining LED_SEQ_PWM_EN.
module led_sequencer #(
  parameter int BITS     = 8,
  parameter int TICK_DIV = 3000000,
  parameter int DUTY     = 4
) (
  input  logic           CLK,
  input  logic           RST,
  led_sequencer_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [1:0] M_COUNT = 2'd0;
  localparam logic [1:0] M_SHIFT = 2'd1;
  localparam logic [1:0] M_FILL  = 2'd2;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BITS-1:0] out_q, out_d;
  logic            down_q, down_d;
  logic [1:0]      mode_q, mode_d;
  logic [BITS-1:0] pat_q, pat_d;
  logic            step_q, step_d;
  logic            arm;
  logic            wrap;

  function automatic logic [BITS-1:0] initial_value(input logic [1:0] mode,
                                                    input logic [BITS-1:0] pat);
    logic [BITS-1:0] v;
    case (mode)
      M_SHIFT: v = BITS'(1);
      2'd3:    v = pat;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Returns {direction_down, next_out}; direction only matters for SHIFT.
  function automatic logic [BITS:0] advance(input logic [1:0]      mode,
                                            input logic [BITS-1:0] cur,
                                            input logic            down);
    logic [BITS-1:0] nxt;
    logic            nd;
    nxt = cur;
    nd  = down;
    case (mode)
      M_COUNT: nxt = cur + BITS'(1);
      M_SHIFT: begin
        // Endpoints reverse direction so each end bit is shown only once per pass.
        if (!down) begin
          if (cur[BITS-1]) begin
            nxt = cur >> 1;
            nd  = 1'b1;
          end else begin
            nxt = cur << 1;
          end
        end else begin
          if (cur[0]) begin
            nxt = cur << 1;
            nd  = 1'b0;
          end else begin
            nxt = cur >> 1;
          end
        end
      end
      M_FILL:  nxt = (&cur) ? '0 : ((cur << 1) | BITS'(1));
      default: nxt = ~cur;
    endcase
    return {nd, nxt};
  endfunction

  assign arm  = bus.START && !bus.STOP;
  assign wrap = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm) state_d = S_LOAD;
      S_LOAD:  state_d = bus.STOP ? S_IDLE : S_RUN;
      S_RUN:   if (bus.STOP) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    out_d   = out_q;
    down_d  = down_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    step_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        out_d   = '0;
        down_d  = 1'b0;
        if (arm) begin
          mode_d = bus.MODE;
          pat_d  = bus.PATTERN;
        end
      end
      S_LOAD: begin
        presc_d = '0;
        down_d  = 1'b0;
        out_d   = bus.STOP ? '0 : initial_value(mode_q, pat_q);
      end
      S_RUN: begin
        // STOP outranks a coincident tick: the bank clears and no step is reported.
        if (bus.STOP) begin
          presc_d = '0;
          out_d   = '0;
          down_d  = 1'b0;
        end else if (wrap) begin
          presc_d         = '0;
          {down_d, out_d} = advance(mode_q, out_q, down_q);
          step_d          = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        presc_d = '0;
        out_d   = '0;
        down_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= '0;
      out_q   <= '0;
      down_q  <= 1'b0;
      mode_q  <= '0;
      pat_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      out_q   <= out_d;
      down_q  <= down_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      step_q  <= step_d;
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [3:0] pwm_q;
  logic       pwm_on;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end

  assign pwm_on = (int'(pwm_q) < DUTY);

  always_comb begin
    bus.OUT  = out_q & {BITS{pwm_on}};
    bus.BUSY = (state_q != S_IDLE);
    bus.STEP = step_q;
  end
`else
  always_comb begin
    bus.OUT  = out_q;
    bus.BUSY = (state_q != S_IDLE);
    bus.STEP = step_q;
  end
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with BITS=8, TICK_DIV=4, DUTY=4.
module tb_led_sequencer;
  localparam int BITS     = 8;
  localparam int TICK_DIV = 4;
  localparam int DUTY     = 4;

  logic CLK = 1'b0;
  logic RST;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [3:0] pwm_m;

  led_sequencer_if #(.BITS(BITS)) bus_if ();

  led_sequencer #(.BITS(BITS), .TICK_DIV(TICK_DIV), .DUTY(DUTY)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  always #5 CLK = ~CLK;

  // Reference PWM phase so OUT expectations hold in the dimmed build as well.
  always @(posedge CLK) begin
    if (RST) pwm_m <= 4'd0;
    else     pwm_m <= pwm_m + 4'd1;
  end

  function automatic logic [31:0] exp_out(input logic [7:0] v);
`ifdef LED_SEQ_PWM_EN
    return (int'(pwm_m) < DUTY) ? {24'd0, v} : 32'd0;
`else
    return {24'd0, v};
`endif
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] shift_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] fill_seq [9]   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                 8'hFF, 8'h00};

  initial begin
    RST            = 1'b1;
    bus_if.START   = 1'b1;
    bus_if.STOP    = 1'b0;
    bus_if.MODE    = 2'd0;
    bus_if.PATTERN = 8'h00;
    tick(2);
    chk("rst_out",  {24'd0, bus_if.OUT}, 32'd0);
    chk("rst_busy", {31'd0, bus_if.BUSY}, 32'd0);
    chk("rst_step", {31'd0, bus_if.STEP}, 32'd0);

    // COUNT mode; START held through reset arms on the first free edge (edge k)
    RST = 1'b0;
    tick(1);
    chk("cnt_load_busy", {31'd0, bus_if.BUSY}, 32'd1);
    chk("cnt_load_out",  {24'd0, bus_if.OUT}, 32'd0);
    bus_if.START = 1'b0;
    tick(1);
    chk("cnt_k1_out",  {24'd0, bus_if.OUT}, exp_out(8'h00));
    chk("cnt_k1_step", {31'd0, bus_if.STEP}, 32'd0);
    tick(3);
    chk("cnt_k4_step", {31'd0, bus_if.STEP}, 32'd0);
    chk("cnt_k4_out",  {24'd0, bus_if.OUT}, exp_out(8'h00));
    tick(1);
    chk("cnt_k5_step", {31'd0, bus_if.STEP}, 32'd1);
    chk("cnt_k5_out",  {24'd0, bus_if.OUT}, exp_out(8'h01));
    tick(1);
    chk("cnt_k6_step", {31'd0, bus_if.STEP}, 32'd0);
    tick(3);
    chk("cnt_k9_step", {31'd0, bus_if.STEP}, 32'd1);
    chk("cnt_k9_out",  {24'd0, bus_if.OUT}, exp_out(8'h02));
    tick(4 * 253);
    chk("cnt_ff_out",  {24'd0, bus_if.OUT}, exp_out(8'hFF));
    tick(4);
    chk("cnt_wrap_out",  {24'd0, bus_if.OUT}, exp_out(8'h00));
    chk("cnt_wrap_step", {31'd0, bus_if.STEP}, 32'd1);

    bus_if.STOP = 1'b1;
    tick(1);
    chk("stop_out",  {24'd0, bus_if.OUT}, 32'd0);
    chk("stop_busy", {31'd0, bus_if.BUSY}, 32'd0);
    bus_if.STOP = 1'b0;

    // SHIFT mode bounce
    bus_if.MODE  = 2'd1;
    bus_if.START = 1'b1;
    tick(1);
    bus_if.START = 1'b0;
    tick(1);
    chk("shf_init", {24'd0, bus_if.OUT}, exp_out(8'h01));
    for (int i = 0; i < 15; i++) begin
      tick(4);
      chk("shf_seq",  {24'd0, bus_if.OUT}, exp_out(shift_seq[i]));
      chk("shf_step", {31'd0, bus_if.STEP}, 32'd1);
    end

    // STOP coinciding with the prescaler wrap
    tick(3);
    bus_if.STOP = 1'b1;
    tick(1);
    chk("stoptick_out",  {24'd0, bus_if.OUT}, 32'd0);
    chk("stoptick_step", {31'd0, bus_if.STEP}, 32'd0);
    chk("stoptick_busy", {31'd0, bus_if.BUSY}, 32'd0);

    // START and STOP together in IDLE
    bus_if.START = 1'b1;
    tick(2);
    chk("startstop_busy", {31'd0, bus_if.BUSY}, 32'd0);
    bus_if.START = 1'b0;
    bus_if.STOP  = 1'b0;

    // FILL mode
    bus_if.MODE  = 2'd2;
    bus_if.START = 1'b1;
    tick(1);
    bus_if.START = 1'b0;
    tick(1);
    chk("fill_init", {24'd0, bus_if.OUT}, exp_out(8'h00));
    for (int i = 0; i < 9; i++) begin
      tick(4);
      chk("fill_seq", {24'd0, bus_if.OUT}, exp_out(fill_seq[i]));
    end
    bus_if.STOP = 1'b1;
    tick(1);
    bus_if.STOP = 1'b0;

    // BLINK mode; MODE/PATTERN changes after the start must not take effect
    bus_if.MODE    = 2'd3;
    bus_if.PATTERN = 8'hA5;
    bus_if.START   = 1'b1;
    tick(1);
    bus_if.START   = 1'b0;
    bus_if.PATTERN = 8'h3C;
    bus_if.MODE    = 2'd0;
    tick(1);
    chk("blink_init", {24'd0, bus_if.OUT}, exp_out(8'hA5));
    tick(4);
    chk("blink_1",    {24'd0, bus_if.OUT}, exp_out(8'h5A));
    chk("blink_step", {31'd0, bus_if.STEP}, 32'd1);
    tick(4);
    chk("blink_2",    {24'd0, bus_if.OUT}, exp_out(8'hA5));

    // Reset in the middle of a run
    tick(2);
    chk("midrun_busy", {31'd0, bus_if.BUSY}, 32'd1);
    RST = 1'b1;
    tick(1);
    chk("midrst_out",  {24'd0, bus_if.OUT}, 32'd0);
    chk("midrst_busy", {31'd0, bus_if.BUSY}, 32'd0);
    chk("midrst_step", {31'd0, bus_if.STEP}, 32'd0);
    RST = 1'b0;
    tick(2);
    chk("post_rst_idle", {31'd0, bus_if.BUSY}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Controller that drives the iCEstick LED/header output bank with selectable animated patterns.
- Replaces the free-running counter-to-pins approach with a start/stop-controlled sequencer.
- A prescaler produces a step tick. A small FSM latches the mode and pattern, advances the output register on each tick, and clears the outputs when stopped.
- Sits between the top-level pin assigns (LED1..LED5, J1/J2/J3 headers) and any control logic (buttons, UART command decoder).

Parameters:
- BITS, 8: width of the output bank.
- TICK_DIV, 3000000: CLK cycles per pattern step (12 MHz gives 4 Hz); legal range ≥ 2.
- DUTY, 4: PWM on-slots out of 16; used only with LED_SEQ_PWM_EN; legal range 0..16.

Ports:
- CLK, in, 1: system clock, 12 MHz.
- RST, in, 1: reset; synchronous, active-high.
- START, in, 1: level sampled each cycle; begins a sequence from IDLE.
- STOP, in, 1: level sampled each cycle; aborts a sequence and returns to IDLE.
- MODE, in, 2: 0=COUNT, 1=SHIFT, 2=FILL, 3=BLINK; latched at start.
- PATTERN, in, BITS: seed for BLINK mode; latched at start.
- OUT, out, BITS: drives the LED/header bank.
- BUSY, out, 1: high whenever state ≠ IDLE.
- STEP, out, 1: one-cycle pulse on each pattern advance.

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RST).
- RST=1 at an edge forces:
  - state=IDLE, OUT=0, BUSY=0, STEP=0
  - prescaler=0, direction=up, latched mode/pattern=0
- RST dominates all other inputs, including mid-sequence.
- States:
  - IDLE: OUT=0, prescaler held at 0.
  - LOAD: one cycle; mode and pattern are already latched.
  - RUN: animation active.
- IDLE→LOAD: START=1 and STOP=0 at edge k. MODE/PATTERN are captured at edge k, and BUSY=1 after edge k. If START and STOP are both high, STOP wins and the FSM stays in IDLE.
- LOAD→RUN: at edge k+1, OUT loads the initial value, prescaler=0, direction=up. Initial values by mode:
  - COUNT: 0
  - SHIFT: 1 (bit0)
  - FILL: 0
  - BLINK: PATTERN
- RUN prescaler: counts 0..TICK_DIV-1, then wraps to 0. At the wrap edge, OUT advances and STEP=1 for that one cycle. First STEP follows edge k+1+TICK_DIV.
- Advance rules (all modulo BITS, no X states):
  - COUNT: OUT+1, wrapping all-ones → 0.
  - SHIFT: single hot bit moves up until bit BITS-1, then down until bit0, then up again. Endpoints are each shown once per pass; with BITS=8 the period is 14 steps.
  - FILL: OUT ← {OUT[BITS-2:0],1}. When OUT is all-ones, the next value is 0. Period is BITS+1.
  - BLINK: OUT ← ~OUT.
- STOP=1 in LOAD or RUN: the next edge gives IDLE, OUT=0, BUSY=0, STEP=0. No step occurs even if the tick coincides.
- START in LOAD/RUN is ignored. MODE/PATTERN changes during RUN are ignored until the next START from IDLE.
- START held high continuously re-arms only after returning to IDLE via STOP (level-sensitive; no edge detect required).
- STEP is never asserted outside RUN.

Optional Feature:
- Macro: LED_SEQ_PWM_EN.
- Defined:
  - A free-running 4-bit PWM counter (reset to 0, increments every CLK) dims the bank.
  - OUT = out_reg & {BITS{pwm_cnt < DUTY}}.
  - DUTY=16 gives full on; DUTY=0 gives always off.
  - Sequencing, BUSY and STEP are unchanged.
- Undefined: OUT = out_reg directly; no PWM counter exists.

Test Plan:
- Reset then idle: RST=1 for 2 cycles with START=1 → OUT=0, BUSY=0, STEP=0; after RST=0, BUSY=1 on the next edge.
- COUNT, TICK_DIV=4, BITS=8, START pulse at edge k:
  - OUT=0x00 at k+1.
  - STEP pulses at k+5, k+9, ….
  - OUT=0x01, 0x02, …; from 0xFF, the next step gives 0x00.
- SHIFT, BITS=8: OUT sequence 01,02,04,…,80,40,20,…,02,01,02 → 14-step period, no repeated endpoints.
- FILL: sequence 00,01,03,07,…,FF,00; BLINK with PATTERN=0xA5 → A5,5A,A5; changing PATTERN during RUN has no effect.
- Control edges:
  - START+STOP together in IDLE → stays IDLE.
  - STOP on the same cycle as a tick → OUT=0, no STEP.
  - RST mid-RUN → all outputs 0 next edge.
- With LED_SEQ_PWM_EN, DUTY=4, BLINK PATTERN=0xFF → OUT=0xFF for 4 of every 16 cycles, 0 otherwise. DUTY=0 → OUT always 0 while BUSY=1.
